// File: rtl/usr_pkg.sv
// Shared types and helpers for the universal shift register.
package usr_pkg;

  typedef enum logic [2:0] {
    HOLD = 3'd0,
    SHR  = 3'd1,
    SHL  = 3'd2,
    LOAD = 3'd3,
    ROR  = 3'd4,
    ROL  = 3'd5,
    ASR  = 3'd6,
    RSVD = 3'd7
  } usr_mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } usr_state_e;

  // Modes that move bits one position per edge and honour the count field.
  function automatic logic is_shift_mode(input usr_mode_e m);
    case (m)
      SHR, SHL, ROR, ROL, ASR: return 1'b1;
      default:                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/usr_shift_step.sv
// Single-position next-value function of the universal shift register.
module usr_shift_step
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  usr_mode_e        mode,
  input  logic [WIDTH-1:0] d,
  input  logic             ser_l_in,
  input  logic             ser_r_in,
  output logic [WIDTH-1:0] next_d
);

  // One shift/rotate step; LOAD, HOLD and reserved leave the value alone here.
  always_comb begin
    next_d = d;
    case (mode)
      SHR:     next_d = {ser_r_in, d[WIDTH-1:1]};
      SHL:     next_d = {d[WIDTH-2:0], ser_l_in};
      ROR:     next_d = {d[0], d[WIDTH-1:1]};
      ROL:     next_d = {d[WIDTH-2:0], d[WIDTH-1]};
      ASR:     next_d = {d[WIDTH-1], d[WIDTH-1:1]};
      default: next_d = d;
    endcase
  end

endmodule

// File: rtl/universal_shift_reg_p.sv
// Parametrised universal shift register with multi-cycle shift-by-N commands.
module universal_shift_reg_p
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             cmd_ready,
  input  logic [2:0]       mode,
  input  logic [CNT_W-1:0] count,
  input  logic [WIDTH-1:0] d_in,
  input  logic             ser_r_in,
  input  logic             ser_l_in,
  output logic [WIDTH-1:0] d_out,
  output logic             ser_r_out,
  output logic             ser_l_out,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  usr_state_e       state_r, state_nx_s;
  usr_mode_e        mode_r, mode_nx_s;
  logic [CNT_W-1:0] rem_r, rem_nx_s;
  logic [WIDTH-1:0] d_r, d_nx_s;
  logic             done_r, done_nx_s;

  usr_mode_e        mode_in_s;
  usr_mode_e        step_mode_s;
  logic [WIDTH-1:0] step_d_s;
  logic             accept_s;

  assign mode_in_s   = usr_mode_e'(mode);
  assign accept_s    = start && (state_r == IDLE);
  // While running, the latched mode drives the step; the live mode input is ignored.
  assign step_mode_s = (state_r == RUN) ? mode_r : mode_in_s;

  usr_shift_step #(.WIDTH(WIDTH)) u_step (
    .mode     (step_mode_s),
    .d        (d_r),
    .ser_l_in (ser_l_in),
    .ser_r_in (ser_r_in),
    .next_d   (step_d_s)
  );

  // Next-state, remaining-count, data and done decode.
  always_comb begin
    state_nx_s = state_r;
    mode_nx_s  = mode_r;
    rem_nx_s   = rem_r;
    d_nx_s     = d_r;
    done_nx_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (mode_in_s == LOAD) begin
            d_nx_s    = d_in;
            done_nx_s = 1'b1;
          end else if (is_shift_mode(mode_in_s)) begin
            if (count == CNT_ZERO) begin
              done_nx_s = 1'b1;
            end else if (count == CNT_ONE) begin
              d_nx_s    = step_d_s;
              done_nx_s = 1'b1;
            end else begin
              d_nx_s     = step_d_s;
              mode_nx_s  = mode_in_s;
              rem_nx_s   = count - CNT_ONE;
              state_nx_s = RUN;
            end
          end else begin
            done_nx_s = 1'b1;
          end
        end else begin
          done_nx_s = 1'b0;
        end
      end
      RUN: begin
        d_nx_s = step_d_s;
        if (rem_r == CNT_ONE) begin
          rem_nx_s   = CNT_ZERO;
          done_nx_s  = 1'b1;
          state_nx_s = IDLE;
        end else begin
          rem_nx_s = rem_r - CNT_ONE;
        end
      end
      default: begin
        state_nx_s = IDLE;
        rem_nx_s   = CNT_ZERO;
      end
    endcase
  end

  // State, count, data and done registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      mode_r  <= HOLD;
      rem_r   <= CNT_ZERO;
      d_r     <= {WIDTH{1'b0}};
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      mode_r  <= mode_nx_s;
      rem_r   <= rem_nx_s;
      d_r     <= d_nx_s;
      done_r  <= done_nx_s;
    end
  end

  assign d_out     = d_r;
  assign done      = done_r;
  assign busy      = (state_r == RUN);
  assign cmd_ready = (state_r == IDLE);
  assign ser_r_out = d_r[0];
  assign ser_l_out = d_r[WIDTH-1];

endmodule

// File: tb/tb_universal_shift_reg_p.sv
// Self-checking bench for universal_shift_reg_p: directed vector table,
// a hand-written mid-run reset sequence and randomized commands vs a model.
module tb_universal_shift_reg_p;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n, start, ser_r_in, ser_l_in;
  logic [2:0]    mode;
  logic [CW-1:0] count;
  logic [W-1:0]  d_in;
  logic [W-1:0]  d_out;
  logic          cmd_ready, ser_r_out, ser_l_out, busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  universal_shift_reg_p #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cmd_ready(cmd_ready),
    .mode(mode), .count(count), .d_in(d_in), .ser_r_in(ser_r_in),
    .ser_l_in(ser_l_in), .d_out(d_out), .ser_r_out(ser_r_out),
    .ser_l_out(ser_l_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst_n;
    logic          start;
    logic [2:0]    mode;
    logic [CW-1:0] count;
    logic [W-1:0]  d_in;
    logic          sl;
    logic          sr;
    logic [W-1:0]  exp_d;
    logic          exp_busy;
    logic          exp_done;
  } vec_t;

  localparam int NV = 26;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [W-1:0] ed, input logic eb, input logic edn);
    check({tag, " d_out"}, 32'(d_out), 32'(ed));
    check({tag, " busy"}, 32'(busy), 32'(eb));
    check({tag, " cmd_ready"}, 32'(cmd_ready), 32'(!eb));
    check({tag, " done"}, 32'(done), 32'(edn));
    check({tag, " ser_r_out"}, 32'(ser_r_out), 32'(ed[0]));
    check({tag, " ser_l_out"}, 32'(ser_l_out), 32'(ed[W-1]));
  endtask

  // Drive one cycle of inputs, clock it, and let outputs settle.
  task automatic cycle(input logic r, input logic s, input logic [2:0] m, input logic [CW-1:0] c,
                       input logic [W-1:0] di, input logic sl, input logic sr);
    rst_n = r; start = s; mode = m; count = c; d_in = di; ser_l_in = sl; ser_r_in = sr;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic s, input logic [2:0] m, input logic [CW-1:0] c,
                              input logic [W-1:0] di, input logic sl, input logic [W-1:0] ed,
                              input logic eb, input logic edn);
    vec_t v;
    v.rst_n = 1'b1; v.start = s; v.mode = m; v.count = c; v.d_in = di;
    v.sl = sl; v.sr = 1'b0; v.exp_d = ed; v.exp_busy = eb; v.exp_done = edn;
    return v;
  endfunction

  // Reference single step from the mode definitions using plain arithmetic.
  function automatic logic [W-1:0] ref_op(input int m, input logic [W-1:0] d, input logic sl, input logic sr);
    logic signed [W-1:0] sd;
    sd = d;
    case (m)
      1: return (d >> 1) | (W'(sr) << (W - 1));
      2: return (d << 1) | W'(sl);
      4: return (d >> 1) | (W'(d & 1) << (W - 1));
      5: return (d << 1) | (d >> (W - 1));
      6: return W'(sd >>> 1);
      default: return d;
    endcase
  endfunction

  initial begin
    // Directed table: inputs for an edge, expected outputs after that edge.
    vecs[0]  = mk(1'b1, 3'd3, 4'd7, 8'hA5, 1'b0, 8'hA5, 1'b0, 1'b1);
    vecs[1]  = mk(1'b0, 3'd0, 4'd0, 8'h00, 1'b0, 8'hA5, 1'b0, 1'b0);
    vecs[2]  = mk(1'b1, 3'd4, 4'd3, 8'h00, 1'b0, 8'hD2, 1'b1, 1'b0);
    vecs[3]  = mk(1'b1, 3'd3, 4'd1, 8'h00, 1'b0, 8'h69, 1'b1, 1'b0);
    vecs[4]  = mk(1'b0, 3'd3, 4'd1, 8'h00, 1'b0, 8'hB4, 1'b0, 1'b1);
    vecs[5]  = mk(1'b0, 3'd0, 4'd0, 8'h00, 1'b0, 8'hB4, 1'b0, 1'b0);
    vecs[6]  = mk(1'b1, 3'd3, 4'd0, 8'h90, 1'b0, 8'h90, 1'b0, 1'b1);
    vecs[7]  = mk(1'b1, 3'd6, 4'd2, 8'h00, 1'b0, 8'hC8, 1'b1, 1'b0);
    vecs[8]  = mk(1'b0, 3'd0, 4'd0, 8'h00, 1'b0, 8'hE4, 1'b0, 1'b1);
    vecs[9]  = mk(1'b1, 3'd3, 4'd0, 8'h0F, 1'b0, 8'h0F, 1'b0, 1'b1);
    vecs[10] = mk(1'b1, 3'd2, 4'd4, 8'h00, 1'b1, 8'h1F, 1'b1, 1'b0);
    vecs[11] = mk(1'b0, 3'd0, 4'd0, 8'h00, 1'b1, 8'h3F, 1'b1, 1'b0);
    vecs[12] = mk(1'b0, 3'd0, 4'd0, 8'h00, 1'b1, 8'h7F, 1'b1, 1'b0);
    vecs[13] = mk(1'b0, 3'd0, 4'd0, 8'h00, 1'b1, 8'hFF, 1'b0, 1'b1);
    vecs[14] = mk(1'b1, 3'd1, 4'd0, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b1);
    vecs[15] = mk(1'b0, 3'd0, 4'd0, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0);
    vecs[16] = mk(1'b1, 3'd3, 4'd0, 8'h81, 1'b0, 8'h81, 1'b0, 1'b1);
    vecs[17] = mk(1'b1, 3'd5, 4'd9, 8'h00, 1'b0, 8'h03, 1'b1, 1'b0);
    vecs[18] = mk(1'b0, 3'd0, 4'd0, 8'h00, 1'b0, 8'h06, 1'b1, 1'b0);
    vecs[19] = mk(1'b0, 3'd0, 4'd0, 8'h00, 1'b0, 8'h0C, 1'b1, 1'b0);
    vecs[20] = mk(1'b0, 3'd0, 4'd0, 8'h00, 1'b0, 8'h18, 1'b1, 1'b0);
    vecs[21] = mk(1'b0, 3'd0, 4'd0, 8'h00, 1'b0, 8'h30, 1'b1, 1'b0);
    vecs[22] = mk(1'b0, 3'd0, 4'd0, 8'h00, 1'b0, 8'h60, 1'b1, 1'b0);
    vecs[23] = mk(1'b0, 3'd0, 4'd0, 8'h00, 1'b0, 8'hC0, 1'b1, 1'b0);
    vecs[24] = mk(1'b0, 3'd0, 4'd0, 8'h00, 1'b0, 8'h81, 1'b1, 1'b0);
    vecs[25] = mk(1'b0, 3'd0, 4'd0, 8'h00, 1'b0, 8'h03, 1'b0, 1'b1);

    // Reset state.
    cycle(1'b0, 1'b0, 3'd0, 4'd0, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 3'd0, 4'd0, 8'h00, 1'b0, 1'b0);
    check_all("reset", 8'h00, 1'b0, 1'b0);

    for (int i = 0; i < NV; i++) begin
      cycle(vecs[i].rst_n, vecs[i].start, vecs[i].mode, vecs[i].count,
            vecs[i].d_in, vecs[i].sl, vecs[i].sr);
      check_all($sformatf("vec%0d", i), vecs[i].exp_d, vecs[i].exp_busy, vecs[i].exp_done);
    end

    // Mid-run reset: ROL 5 from 0x01, reset after two shift edges, no done pulse.
    cycle(1'b1, 1'b1, 3'd3, 4'd0, 8'h01, 1'b0, 1'b0);
    check_all("midrst load", 8'h01, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 3'd5, 4'd5, 8'h00, 1'b0, 1'b0);
    check_all("midrst e1", 8'h02, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 3'd0, 4'd0, 8'h00, 1'b0, 1'b0);
    check_all("midrst e2", 8'h04, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 3'd0, 4'd0, 8'h00, 1'b0, 1'b0);
    check_all("midrst rst", 8'h00, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 3'd0, 4'd0, 8'h00, 1'b0, 1'b0);
    check_all("midrst after", 8'h00, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 3'd7, 4'd6, 8'h5A, 1'b0, 1'b0);
    check_all("rsvd accept", 8'h00, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 3'd0, 4'd0, 8'h00, 1'b0, 1'b0);
    check_all("rsvd after", 8'h00, 1'b0, 1'b0);

    // Randomized run against a count-of-pending-shifts model.
    begin
      logic [W-1:0] m_d;
      int           m_left;
      int           m_mode;
      logic         m_done;
      logic         r, s, sl, sr;
      logic [2:0]   md;
      logic [CW-1:0] c;
      logic [W-1:0] di;
      m_d = 8'h00; m_left = 0; m_mode = 0; m_done = 1'b0;
      for (int k = 0; k < 400; k++) begin
        r  = ($urandom_range(0, 59) != 0);
        s  = ($urandom_range(0, 2) != 0);
        md = 3'($urandom_range(0, 7));
        c  = CW'($urandom_range(0, 12));
        di = W'($urandom);
        sl = 1'($urandom);
        sr = 1'($urandom);
        if (!r) begin
          m_d = 8'h00; m_left = 0; m_done = 1'b0;
        end else if (m_left > 0) begin
          m_d = ref_op(m_mode, m_d, sl, sr);
          m_left--;
          m_done = (m_left == 0);
        end else if (s) begin
          m_done = 1'b1;
          if (md == 3'd3) begin
            m_d = di;
          end else if (md inside {3'd1, 3'd2, 3'd4, 3'd5, 3'd6} && c != 0) begin
            m_d = ref_op(int'(md), m_d, sl, sr);
            m_mode = int'(md);
            m_left = int'(c) - 1;
            m_done = (m_left == 0);
          end
        end else begin
          m_done = 1'b0;
        end
        cycle(r, s, md, c, di, sl, sr);
        check_all($sformatf("rand%0d", k), m_d, (m_left > 0), m_done);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
